// File: rtl/tune_if.sv
// Control/data bundle between tune_accum, the encoder handler and the
// tuning-word consumer.
interface tune_if #(
  parameter int W = 32
);
  logic signed [7:0] enc_move;
  logic              read_enable;
  logic [1:0]        step_sel;
  logic              load;
  logic [W-1:0]      load_value;
  logic [W-1:0]      value;
  logic              changed;

  modport master (
    output enc_move, step_sel, load, load_value,
    input  read_enable, value, changed
  );

  modport slave (
    input  enc_move, step_sel, load, load_value,
    output read_enable, value, changed
  );
endinterface

// File: rtl/tune_accum.sv
// Polls the encoder, scales the detent count and accumulates a clamped word.
// Optional x4 acceleration for fast spins: define TUNE_ACCEL_EN.
module tune_accum #(
  parameter int          W            = 32,
  parameter int          POLL_CYCLES  = 160000,
  parameter int          HOLD_CYCLES  = 4,
  parameter int unsigned STEP0        = 1,
  parameter int unsigned STEP1        = 10,
  parameter int unsigned STEP2        = 100,
  parameter int unsigned STEP3        = 1000,
  parameter logic [W-1:0] VMIN        = W'(0),
  parameter logic [W-1:0] VMAX        = W'(30000000),
  parameter logic [W-1:0] VINIT       = W'(7000000),
  parameter int          ACCEL_THRESH = 4
) (
  input  logic  aclk,
  input  logic  aresetn,
  tune_if.slave bus
);

  localparam int WD = W + 26;
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);

`ifdef TUNE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam logic signed [WD-1:0] VMIN_X = {{(WD-W){1'b0}}, VMIN};
  localparam logic signed [WD-1:0] VMAX_X = {{(WD-W){1'b0}}, VMAX};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_CAPTURE,
    S_CALC,
    S_UPDATE
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          poll_q, poll_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   re_q, re_d;
  logic signed [7:0]      cnt_q, cnt_d;
  logic signed [WD-1:0]   delta_q, delta_d;
  logic [W-1:0]           value_q, value_d;
  logic                   changed_q, changed_d;

  logic                   poll_wrap;
  logic [15:0]            step_v;
  logic signed [WD-1:0]   delta_c;
  logic signed [WD-1:0]   sum_c;
  logic [W-1:0]           upd_val;
  logic [W-1:0]           load_val;
  logic                   acc_hit;

  assign poll_wrap = (poll_q == PW'(POLL_CYCLES - 1));

  always_comb begin
    step_v = 16'(STEP0);
    unique case (bus.step_sel)
      2'd0: step_v = 16'(STEP0);
      2'd1: step_v = 16'(STEP1);
      2'd2: step_v = 16'(STEP2);
      2'd3: step_v = 16'(STEP3);
      default: step_v = 16'(STEP0);
    endcase
  end

  // Product and shift both live in WD bits so -128 x 1000 x 4 stays exact.
  always_comb begin
    acc_hit = ACCEL_ON &&
              ((int'(cnt_q) >= ACCEL_THRESH) ||
               (int'(cnt_q) <= -ACCEL_THRESH));
    delta_c = {{(WD-8){cnt_q[7]}}, cnt_q} *
              $signed({{(WD-16){1'b0}}, step_v});
    if (acc_hit) delta_c = delta_c <<< 2;
  end

  always_comb begin
    sum_c = $signed({{(WD-W){1'b0}}, value_q}) + delta_q;
    if (sum_c < VMIN_X)      upd_val = VMIN;
    else if (sum_c > VMAX_X) upd_val = VMAX;
    else                     upd_val = sum_c[W-1:0];
  end

  always_comb begin
    if (bus.load_value < VMIN)      load_val = VMIN;
    else if (bus.load_value > VMAX) load_val = VMAX;
    else                            load_val = bus.load_value;
  end

  always_comb begin
    state_d = state_q;
    poll_d  = poll_wrap ? '0 : poll_q + 1'b1;
    hold_d  = hold_q;
    re_d    = re_q;
    cnt_d   = cnt_q;
    delta_d = delta_q;
    value_d = value_q;
    unique case (state_q)
      S_IDLE: begin
        if (poll_wrap) begin
          state_d = S_ASSERT;
          re_d    = 1'b1;
          hold_d  = '0;
        end
      end
      S_ASSERT: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = S_CAPTURE;
          re_d    = 1'b0;
          cnt_d   = bus.enc_move;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_CAPTURE: state_d = S_CALC;
      S_CALC: begin
        delta_d = delta_c;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        value_d = upd_val;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.load) value_d = load_val;
    changed_d = (value_d != value_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      hold_q    <= '0;
      re_q      <= 1'b0;
      cnt_q     <= '0;
      delta_q   <= '0;
      value_q   <= VINIT;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      hold_q    <= hold_d;
      re_q      <= re_d;
      cnt_q     <= cnt_d;
      delta_q   <= delta_d;
      value_q   <= value_d;
      changed_q <= changed_d;
    end
  end

  assign bus.read_enable = re_q;
  assign bus.value       = value_q;
  assign bus.changed     = changed_q;

endmodule
